// File: rtl/snes_pad_scan.sv
// snes_pad_scan: SNES/NES controller scanner. Drives latch/clock, shifts NUM_PADS
// data lines in parallel and publishes an atomic active-high snapshot per frame.
// Optional feature macro: SNES_PAD_PRESENT_EN (one extra bit per pad as presence flag).
module snes_pad_scan #(
  parameter int unsigned NUM_PADS   = 2,
  parameter int unsigned NBITS      = 16,
  parameter int unsigned TICK_DIV   = 288,
  parameter int unsigned AUTO_TICKS = 2778
) (
  input  logic                      CLK6X,
  input  logic                      RSTn,
  input  logic                      start_i,
  input  logic                      auto_en_i,
  output logic                      NESLATCH,
  output logic                      NESCLOCK,
  input  logic [NUM_PADS-1:0]       NESDATA,
  output logic [NUM_PADS*NBITS-1:0] pad_data_o,
  output logic                      valid_o,
  output logic                      busy_o,
  output logic [NUM_PADS-1:0]       present_o
);

  localparam int unsigned DW = $clog2(TICK_DIV + 1);
  localparam int unsigned AW = $clog2(AUTO_TICKS + 1);
  localparam int unsigned BW = $clog2(NBITS + 1);
  localparam int unsigned IW = (NBITS > 1) ? $clog2(NBITS) : 1;
`ifdef SNES_PAD_PRESENT_EN
  localparam logic [BW-1:0] ExtraBit = BW'(NBITS);
  localparam logic [BW-1:0] LastBit  = BW'(NBITS);
`else
  localparam logic [BW-1:0] LastBit  = BW'(NBITS - 1);
`endif

  typedef enum logic [2:0] {StIdle, StLatch, StLow, StHigh, StDone} state_e;

  state_e                             state_q, state_d;
  logic [DW-1:0]                      div_q, div_d;
  logic [BW-1:0]                      bit_q, bit_d;
  logic                               latch_ph_q, latch_ph_d;
  logic [NUM_PADS-1:0]                sync1_q, sync2_q;
  logic [NUM_PADS-1:0][NBITS-1:0]     shift_q, pad_q;
  logic                               latch_q, clk_q, valid_q, busy_q;
  logic [DW-1:0]                      auto_div_q;
  logic [AW-1:0]                      auto_cnt_q;
  logic                               tick, auto_tick, auto_start, scan_start;
  logic                               sample_en, sample_data;
  logic [IW-1:0]                      sidx;
`ifdef SNES_PAD_PRESENT_EN
  logic                               sample_extra;
  logic [NUM_PADS-1:0]                raw_q, present_q;
`endif

  // Tick strobes for the scan divider and the free-running auto divider.
  always_comb begin
    tick       = (state_q != StIdle) && (div_q == DW'(TICK_DIV - 1));
    auto_tick  = (auto_div_q == DW'(TICK_DIV - 1));
    auto_start = auto_en_i && (state_q == StIdle) && auto_tick &&
                 (auto_cnt_q == AW'(AUTO_TICKS - 1));
    scan_start = start_i || auto_start;
  end

  // Next-state logic; divider is pinned to 0 in idle so the first tick lands TICK_DIV later.
  always_comb begin
    state_d    = state_q;
    bit_d      = bit_q;
    latch_ph_d = latch_ph_q;
    div_d      = (state_q == StIdle || tick) ? '0 : div_q + 1'b1;
    unique case (state_q)
      StIdle: begin
        if (scan_start) begin
          state_d    = StLatch;
          bit_d      = '0;
          latch_ph_d = 1'b0;
        end
      end
      StLatch: begin
        if (tick) begin
          if (latch_ph_q) state_d = StLow;
          else            latch_ph_d = 1'b1;
        end
      end
      StLow: begin
        if (tick) state_d = StHigh;
      end
      StHigh: begin
        if (tick) begin
          if (bit_q == LastBit) begin
            state_d = StDone;
          end else begin
            bit_d   = bit_q + 1'b1;
            state_d = StLow;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Sample on the edge that enters LOW, i.e. the same edge that drops NESCLOCK.
  always_comb begin
    sample_en    = (state_q != StLow) && (state_d == StLow);
    sidx         = bit_d[IW-1:0];
`ifdef SNES_PAD_PRESENT_EN
    sample_extra = sample_en && (bit_d == ExtraBit);
    sample_data  = sample_en && !sample_extra;
`else
    sample_data  = sample_en;
`endif
  end

  // FSM state, registered pad lines and frame-atomic output publication.
  always_ff @(posedge CLK6X or negedge RSTn) begin
    if (!RSTn) begin
      state_q    <= StIdle;
      div_q      <= '0;
      bit_q      <= '0;
      latch_ph_q <= 1'b0;
      latch_q    <= 1'b0;
      clk_q      <= 1'b1;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      pad_q      <= '0;
`ifdef SNES_PAD_PRESENT_EN
      present_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      latch_ph_q <= latch_ph_d;
      latch_q    <= (state_d == StLatch);
      clk_q      <= (state_d != StLow);
      busy_q     <= (state_d != StIdle);
      valid_q    <= (state_q == StDone);
      if (state_q == StDone) begin
`ifdef SNES_PAD_PRESENT_EN
        for (int p = 0; p < int'(NUM_PADS); p++) begin
          pad_q[p] <= raw_q[p] ? '0 : shift_q[p];
        end
        present_q <= ~raw_q;
`else
        pad_q <= shift_q;
`endif
      end
    end
  end

  // Two-flop synchroniser per data line; idle level is high (released).
  always_ff @(posedge CLK6X or negedge RSTn) begin
    if (!RSTn) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= NESDATA;
      sync2_q <= sync1_q;
    end
  end

  // Shift capture; pad lines are active low so data bits are stored inverted.
  always_ff @(posedge CLK6X or negedge RSTn) begin
    if (!RSTn) begin
      shift_q <= '0;
`ifdef SNES_PAD_PRESENT_EN
      raw_q   <= '1;
`endif
    end else begin
      if (sample_data) begin
        for (int p = 0; p < int'(NUM_PADS); p++) begin
          shift_q[p][sidx] <= ~sync2_q[p];
        end
      end
`ifdef SNES_PAD_PRESENT_EN
      if (sample_extra) raw_q <= sync2_q;
`endif
    end
  end

  // Auto-scan timer: advances only while enabled and idle, cleared when disabled.
  always_ff @(posedge CLK6X or negedge RSTn) begin
    if (!RSTn) begin
      auto_div_q <= '0;
      auto_cnt_q <= '0;
    end else if (!auto_en_i) begin
      auto_div_q <= '0;
      auto_cnt_q <= '0;
    end else if (state_q == StIdle) begin
      if (auto_tick) begin
        auto_div_q <= '0;
        auto_cnt_q <= (auto_cnt_q == AW'(AUTO_TICKS - 1)) ? '0 : auto_cnt_q + 1'b1;
      end else begin
        auto_div_q <= auto_div_q + 1'b1;
      end
    end
  end

  assign NESLATCH   = latch_q;
  assign NESCLOCK   = clk_q;
  assign pad_data_o = pad_q;
  assign valid_o    = valid_q;
  assign busy_o     = busy_q;
`ifdef SNES_PAD_PRESENT_EN
  assign present_o  = present_q;
`else
  assign present_o  = '1;
`endif

endmodule

// File: tb/tb_snes_pad_scan.sv
// tb_snes_pad_scan: directed bench with a pad model and a scoreboard of expected snapshots.
`timescale 1ns/1ps
module tb_snes_pad_scan;

  localparam int unsigned NP = 2;
  localparam int unsigned NB = 16;
  localparam int unsigned TD = 4;
  localparam int unsigned AT = 10;
`ifdef SNES_PAD_PRESENT_EN
  localparam int FB = NB + 1;
`else
  localparam int FB = NB;
`endif
  localparam int FRAME  = TD * (2 + 2 * FB) + 1;
  localparam int BUDGET = 400;

  logic              CLK6X = 1'b0;
  logic              RSTn = 1'b0;
  logic              start_i = 1'b0;
  logic              auto_en_i = 1'b0;
  logic              NESLATCH, NESCLOCK;
  logic [NP-1:0]     NESDATA;
  logic [NP*NB-1:0]  pad_data_o;
  logic              valid_o, busy_o;
  logic [NP-1:0]     present_o;

  int vectors = 0;
  int miscompares = 0;
  int valid_cnt = 0;
  logic [NP*NB-1:0]       sb[$];
  logic [NP-1:0][NB-1:0]  pat = '0;
  logic [NP-1:0]          absent = '0;
  logic [NP-1:0]          exp_present = '1;
  logic [5:0]             pidx = '0;

  snes_pad_scan #(
    .NUM_PADS  (NP),
    .NBITS     (NB),
    .TICK_DIV  (TD),
    .AUTO_TICKS(AT)
  ) dut (
    .CLK6X     (CLK6X),
    .RSTn      (RSTn),
    .start_i   (start_i),
    .auto_en_i (auto_en_i),
    .NESLATCH  (NESLATCH),
    .NESCLOCK  (NESCLOCK),
    .NESDATA   (NESDATA),
    .pad_data_o(pad_data_o),
    .valid_o   (valid_o),
    .busy_o    (busy_o),
    .present_o (present_o)
  );

  always #5 CLK6X = ~CLK6X;

  // Pad model: latch loads bit 0, each rising clock edge advances; data active low.
  always @(posedge NESLATCH) pidx = '0;
  always @(posedge NESCLOCK) if (NESLATCH === 1'b0 && pidx != 6'd63) pidx = pidx + 1'b1;

  always_comb begin
    NESDATA = '1;
    for (int p = 0; p < int'(NP); p++) begin
      if (absent[p])           NESDATA[p] = 1'b1;
      else if (pidx < 6'(NB))  NESDATA[p] = ~pat[p][pidx[3:0]];
      else                     NESDATA[p] = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NP*NB-1:0] model_data();
    logic [NP*NB-1:0] e;
    e = '0;
    for (int p = 0; p < int'(NP); p++) e[p*NB +: NB] = absent[p] ? '0 : pat[p];
    return e;
  endfunction

  function automatic logic [NP-1:0] model_present();
`ifdef SNES_PAD_PRESENT_EN
    return ~absent;
`else
    return '1;
`endif
  endfunction

  // Scoreboard consumer: every valid pulse must match the oldest expected snapshot.
  always @(negedge CLK6X) begin
    if (RSTn && valid_o === 1'b1) begin
      valid_cnt++;
      check("sb_has_entry", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        check("pad_data", pad_data_o, sb.pop_front());
        check("present", present_o, exp_present);
      end
    end
  end

  // Called on the first negedge of a frame; returns on the negedge where valid_o is seen.
  task automatic measure(input string tag);
    int lat = 0, clo = 0, pulses = 0, bad_busy = 0, cyc = 0, vcyc = -1;
    logic prev = 1'b1;
    while (vcyc < 0 && cyc < BUDGET) begin
      if (NESLATCH) lat++;
      if (!NESCLOCK) clo++;
      if (prev && !NESCLOCK) pulses++;
      prev = NESCLOCK;
      if (valid_o) begin
        vcyc = cyc;
        if (busy_o) bad_busy++;
      end else if (!busy_o) begin
        bad_busy++;
      end
      cyc++;
      if (vcyc < 0) @(negedge CLK6X);
    end
    check({tag, "_len"}, 64'(vcyc), 64'(FRAME));
    check({tag, "_latch"}, 64'(lat), 64'(2 * TD));
    check({tag, "_clk_low"}, 64'(clo), 64'(TD * FB));
    check({tag, "_pulses"}, 64'(pulses), 64'(FB));
    check({tag, "_busy"}, 64'(bad_busy), 64'd0);
  endtask

  task automatic scan(input string tag);
    int v0;
    v0 = valid_cnt;
    sb.push_back(model_data());
    exp_present = model_present();
    start_i = 1'b1;
    @(negedge CLK6X);
    start_i = 1'b0;
    measure(tag);
    @(negedge CLK6X);
    check({tag, "_valids"}, 64'(valid_cnt - v0), 64'd1);
  endtask

  task automatic wait_latch(input string tag, input int exp_gap);
    int cnt = 0;
    while (!NESLATCH && cnt < BUDGET) begin
      @(negedge CLK6X);
      cnt++;
    end
    check({tag, "_gap"}, 64'(cnt), 64'(exp_gap));
  endtask

  initial begin
    int v0;
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0;
    // Reset values while reset is held.
    @(negedge CLK6X);
    @(negedge CLK6X);
    check("rst_latch", 64'(NESLATCH), 64'd0);
    check("rst_clock", 64'(NESCLOCK), 64'd1);
    check("rst_data", pad_data_o, 64'd0);
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
`ifdef SNES_PAD_PRESENT_EN
    check("rst_present", 64'(present_o), 64'd0);
`else
    check("rst_present", 64'(present_o), 64'h3);
`endif
    RSTn = 1'b1;
    repeat (3) @(negedge CLK6X);

    // Nothing pressed.
    pat = '0;
    scan("idle_pads");

    // Distinct patterns per pad.
    pat[0] = 16'hA5C3;
    pat[1] = 16'h0001;
    scan("pattern");

    // start_i held every cycle through the frame: one frame, then a fresh one from idle.
    pat[0] = 16'h8000;
    pat[1] = 16'hFFFF;
    v0 = valid_cnt;
    sb.push_back(model_data());
    sb.push_back(model_data());
    exp_present = model_present();
    start_i = 1'b1;
    @(negedge CLK6X);
    measure("spam1");
    @(negedge CLK6X);
    start_i = 1'b0;
    check("spam2_started", 64'(NESLATCH), 64'd1);
    measure("spam2");
    repeat (5) @(negedge CLK6X);
    check("spam_valids", 64'(valid_cnt - v0), 64'd2);
    check("spam_idle", 64'(busy_o), 64'd0);

    // Periodic scans every AT*TD idle cycles; disabling mid-scan lets the frame finish.
    pat[0] = 16'h5A5A;
    pat[1] = 16'h1234;
    exp_present = model_present();
    sb.push_back(model_data());
    auto_en_i = 1'b1;
    wait_latch("auto1", int'(AT * TD));
    measure("auto1");
    sb.push_back(model_data());
    wait_latch("auto2", int'(AT * TD));
    repeat (20) @(negedge CLK6X);
    auto_en_i = 1'b0;
    v0 = valid_cnt;
    begin
      int cnt = 0;
      while (!valid_o && cnt < BUDGET) begin
        @(negedge CLK6X);
        cnt++;
      end
      check("auto2_completes", 64'(valid_o), 64'd1);
    end
    @(negedge CLK6X);
    v0 = valid_cnt;
    repeat (3 * AT * TD) @(negedge CLK6X);
    check("auto_stopped_valids", 64'(valid_cnt - v0), 64'd0);
    check("auto_stopped_busy", 64'(busy_o), 64'd0);

    // Reset during bit 7: immediate return to idle levels, no valid pulse.
    v0 = valid_cnt;
    start_i = 1'b1;
    @(negedge CLK6X);
    start_i = 1'b0;
    repeat (2 * TD + 7 * 2 * TD + 2) @(negedge CLK6X);
    check("mid_clock_low", 64'(NESCLOCK), 64'd0);
    #2;
    RSTn = 1'b0;
    #1;
    check("mid_rst_latch", 64'(NESLATCH), 64'd0);
    check("mid_rst_clock", 64'(NESCLOCK), 64'd1);
    check("mid_rst_data", pad_data_o, 64'd0);
    check("mid_rst_busy", 64'(busy_o), 64'd0);
    repeat (2) @(negedge CLK6X);
    RSTn = 1'b1;
    repeat (FRAME + 20) @(negedge CLK6X);
    check("mid_rst_no_valid", 64'(valid_cnt - v0), 64'd0);
    pat[0] = 16'h0F0F;
    pat[1] = 16'hF0F0;
    scan("after_rst");

    // Pad 1 disconnected: its line floats high for the whole frame.
    absent = 2'b10;
    pat[0] = 16'hA5C3;
    pat[1] = 16'hFFFF;
    scan("pad1_absent");

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/snes_pad_scan.md
Name: snes_pad_scan

Overview:
- Parametrised SNES/NES controller scanner. Generalises the fixed two-pad NESLATCH/NESCLOCK/NESDATA0/NESDATA1 path to NUM_PADS data lines and NBITS bits per frame.
- Generates the latch/clock waveform, shifts all pads in parallel, and publishes a frame-atomic snapshot of active-high button bits.
- Sits between the top-level pad pins and the nora register/IO logic. Scans on demand or periodically.

Parameters:
- NUM_PADS, 2, number of data lines shifted in parallel (1..8).
- NBITS, 16, bits read per pad per frame (8 for NES, 16 for SNES, up to 32).
- TICK_DIV, 288, CLK6X cycles per timing tick (288 at 48 MHz = 6 us).
- AUTO_TICKS, 2778, ticks between automatic scan starts (~16.7 ms).

Ports:
- CLK6X  input  1  system clock (48 MHz).
- RSTn  input  1  asynchronous active-low reset.
- start_i  input  1  one-cycle scan request.
- auto_en_i  input  1  enables periodic scans every AUTO_TICKS.
- NESLATCH  output  1  pad latch, active high.
- NESCLOCK  output  1  pad clock, idles high.
- NESDATA  input  NUM_PADS  serial data from the pads, active low.
- pad_data_o  output  NUM_PADS*NBITS  snapshot; bit p*NBITS+k is pad p, bit k; 1 = pressed.
- valid_o  output  1  one-cycle pulse when pad_data_o updates.
- busy_o  output  1  high from scan start until the DONE cycle.
- present_o  output  NUM_PADS  pad-present flags (optional feature).

Behaviour:
- Reset: async, all outputs take their reset values immediately.
  - NESLATCH=0, NESCLOCK=1, pad_data_o=0, valid_o=0, busy_o=0, present_o=0.
  - FSM=IDLE; divider, bit counter and auto timer all 0.
- NESDATA is passed through a 2-flop synchroniser per line. All samples use the synchronised value.
- Tick divider counts 0..TICK_DIV-1, and tick fires when the count reaches TICK_DIV-1.
  - The divider is held at 0 in IDLE.
  - It restarts at 0 on the cycle the FSM leaves IDLE, so the first tick occurs TICK_DIV cycles after the start.
- Auto timer:
  - Counts ticks while auto_en_i=1 and the FSM is in IDLE. It is free-running on its own tick divider, independent of the scan divider.
  - At AUTO_TICKS-1 it raises an internal start and clears to 0.
  - Clears to 0 when auto_en_i=0.
- Scan start = start_i OR auto start, accepted only in IDLE.
  - A start while busy_o=1 is ignored and is not queued.
  - A simultaneous start_i and auto start produce one scan.
- FSM:
  - IDLE: NESLATCH=0, NESCLOCK=1. On accepted start go to LATCH, set busy_o=1, clear the bit counter.
  - LATCH: NESLATCH=1 for 2 ticks (12 us), then go to LOW with NESLATCH=0.
  - LOW:
    - On entry (the same edge that drives NESCLOCK=0), sample each synchronised NESDATA[p] into shift[p][k] as its inverse.
    - Hold NESCLOCK=0 for 1 tick, then go to HIGH.
  - HIGH: NESCLOCK=1 for 1 tick.
    - If k==NBITS-1 (or the last present-check bit, see the optional feature), go to DONE.
    - Otherwise k++ and go to LOW.
  - DONE: one cycle. Copy all shift registers to pad_data_o, pulse valid_o=1, set busy_o=0, go to IDLE.
- Frame length is (2 + 2*NBITS) ticks plus 1 cycle. Default: 34 ticks = 204 us.
- pad_data_o changes only in DONE. It is never partially updated.
- Bit ordering: the first bit shifted (SNES B) is k=0. Bits above NBITS-1 do not exist.
- Reset asserted mid-scan: abort immediately, lines return to idle levels, pad_data_o cleared. No valid_o pulse.
- auto_en_i dropping mid-scan: the scan in progress completes normally.

Optional Feature:
- Macro: SNES_PAD_PRESENT_EN.
- Defined:
  - After bit NBITS-1, run 1 extra LOW/HIGH pair (frame = 2 + 2*(NBITS+1) ticks).
  - Sample the raw synchronised NESDATA[p] for the extra bit. A connected pad drives 0; an absent pad pulls up to 1.
  - In DONE: present_o[p] = ~raw_extra[p].
  - When present_o[p]=0, that pad's pad_data_o slice is forced to 0.
- Undefined: no extra bit is read, present_o is tied to all-ones (not reset to 0), and pad_data_o is never masked.

Test Plan:
- Reset then start_i with NUM_PADS=2, NBITS=16, TICK_DIV=4, NESDATA=2'b11:
  - NESLATCH high for 8 cycles, then 16 NESCLOCK low/high pairs of 4+4 cycles.
  - valid_o pulses once; pad_data_o=32'h0; busy_o falls in the same cycle as valid_o.
- Pad0 model returns pattern 16'hA5C3 (pressed=1), pad1 returns 16'h0001: pad_data_o=32'h0001_A5C3 after valid_o.
- start_i repeated every cycle during a scan: exactly one valid_o pulse per frame, and the second frame starts only after IDLE.
- auto_en_i=1, AUTO_TICKS=10, TICK_DIV=4: scans start every 40 IDLE cycles. Deasserting auto_en_i stops further starts; the in-flight scan completes.
- RSTn low at bit 7: outputs go immediately to NESLATCH=0, NESCLOCK=1, pad_data_o=0. No valid_o pulse; the next start_i scans normally.
- SNES_PAD_PRESENT_EN, pad1 line held high (absent), pad0 modelled:
  - present_o=2'b01 and pad1's slice=0.
  - Frame is 17 clock pairs.
